multi_pwm_ramp_gen: RTL and testbench

- Parametrised, multi-channel successor to the single-channel RPM-to-PWM generator.
- Converts per-channel RPM commands into fixed-frequency PWM, with duty 0–100% over 0–CMD_MAX rpm.
- Adds command saturation, period-boundary command latching, slew-rate limiting and graceful ramp-down on disable.
- Sits between the command/control logic and the motor-driver output pins.

---
 rtl/multi_pwm_ramp_gen.sv | 155 +++++++++++++++
 tb/tb_multi_pwm_ramp_gen.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/multi_pwm_ramp_gen.sv
// -----------------------------------------------------------------------------
// multi_pwm_ramp_gen
//
// Multi-channel RPM-to-PWM generator. A free-running period counter defines a
// fixed PWM frequency shared by every channel. At each counter wrap, every
// channel latches its command. The command is saturated to CMD_MAX, forced to
// zero while enable is low, and slew-limited by RAMP_STEP per period. The
// result is the effective command, which sets that channel's duty cycle.
//
// Parameters
//   CLK_HZ     clock frequency in Hz
//   PWM_HZ     PWM frequency in Hz; PERIOD = CLK_HZ / PWM_HZ clock cycles
//   CHANNELS   number of independent PWM outputs
//   CMD_W      width of one RPM command
//   CMD_MAX    RPM giving 100% duty. Requires PERIOD % CMD_MAX == 0 and
//              CMD_MAX + RAMP_STEP < 2**CMD_W.
//   RAMP_STEP  largest change of the effective command per period
//              (0 = no slew limit)
//
// Ports
//   clk           system clock
//   rst           synchronous, active-high reset
//   enable        run request; low ramps every channel toward 0
//   rpm_command   packed commands, channel i = [i*CMD_W +: CMD_W]
//   pwm           registered PWM outputs, one bit per channel
//   period_start  registered, high during the cycle where the counter is 0
//   cmd_eff       packed slew-limited effective commands
//   sat           registered, set when the latched command exceeded CMD_MAX
//
// Optional feature
//   PWM_PHASE_STAGGER_EN  When this macro is defined, channel i's high window
//                         starts at cnt == i*(PERIOD/CHANNELS) instead of 0.
//                         Commands are still latched at the global wrap.
// -----------------------------------------------------------------------------
module multi_pwm_ramp_gen #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int PWM_HZ    = 100,
  parameter int CHANNELS  = 2,
  parameter int CMD_W     = 16,
  parameter int CMD_MAX   = 10_000,
  parameter int RAMP_STEP = 100
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [CHANNELS*CMD_W-1:0] rpm_command,
  output logic [CHANNELS-1:0]       pwm,
  output logic                      period_start,
  output logic [CHANNELS*CMD_W-1:0] cmd_eff,
  output logic [CHANNELS-1:0]       sat
);

  localparam int PERIOD = CLK_HZ / PWM_HZ;
  localparam int CNT_W  = $clog2(PERIOD);
  localparam int DUTY_W = $clog2(PERIOD + 1);
  localparam int TPU    = PERIOD / CMD_MAX;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PERIOD - 1);
  localparam logic [CMD_W-1:0]  CMD_MAX_C = CMD_W'(CMD_MAX);
  localparam logic [CMD_W-1:0]  STEP_C    = CMD_W'(RAMP_STEP);
  localparam logic [DUTY_W-1:0] TPU_C     = DUTY_W'(TPU);

  logic [CNT_W-1:0]    cnt_q;
  logic                wrap;
  logic [CMD_W-1:0]    eff_q [CHANNELS];
  logic [CMD_W-1:0]    eff_d [CHANNELS];
  logic [CHANNELS-1:0] sat_d;
  logic [CHANNELS-1:0] pwm_d;

  assign wrap = (cnt_q == CNT_LAST);

  // Move cur toward target by at most RAMP_STEP. Both operands are bounded by
  // CMD_MAX, so cur + STEP_C cannot overflow CMD_W bits.
  function automatic logic [CMD_W-1:0] slew(input logic [CMD_W-1:0] cur,
                                            input logic [CMD_W-1:0] target);
    logic [CMD_W-1:0] diff;
    logic             up;
    up   = (target >= cur);
    diff = up ? (target - cur) : (cur - target);
    if (RAMP_STEP == 0 || diff <= STEP_C) return target;
    return up ? (cur + STEP_C) : (cur - STEP_C);
  endfunction

  // Value that channel ch compares against its duty.
  function automatic logic [DUTY_W-1:0] phase_of(input logic [CNT_W-1:0] cnt,
                                                 input int ch);
`ifdef PWM_PHASE_STAGGER_EN
    // One extra bit holds cnt + PERIOD - offset, which is below 2*PERIOD.
    logic [CNT_W:0] sum;
    sum = (CNT_W + 1)'(cnt) + (CNT_W + 1)'(PERIOD - ch * (PERIOD / CHANNELS));
    if (sum >= (CNT_W + 1)'(PERIOD)) sum = sum - (CNT_W + 1)'(PERIOD);
    return DUTY_W'(sum);
`else
    if (ch < 0) return '0;  // never true; keeps ch referenced in this build
    return DUTY_W'(cnt);
`endif
  endfunction

  // Next effective command and saturation flag per channel. These values are
  // used only when the counter wraps.
  always_comb begin
    // NOTE: each combinational output gets a default before any branch. No
    // path can leave a value unassigned, so no latch is inferred.
    sat_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      logic [CMD_W-1:0] cmd_i;
      logic [CMD_W-1:0] target;
      logic             over;
      cmd_i    = rpm_command[i*CMD_W +: CMD_W];
      over     = (cmd_i > CMD_MAX_C);
      target   = !enable ? '0 : (over ? CMD_MAX_C : cmd_i);
      sat_d[i] = enable && over;
      eff_d[i] = slew(eff_q[i], target);
    end
  end

  // Duty compare. The constant multiply is bounded by PERIOD, so it fits in
  // DUTY_W bits. Full duty keeps every phase below duty, so pwm never drops
  // across the wrap.
  always_comb begin
    pwm_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      logic [DUTY_W-1:0] duty;
      duty     = DUTY_W'(eff_q[i]) * TPU_C;
      pwm_d[i] = (phase_of(cnt_q, i) < duty);
    end
  end

  // NOTE: state registers use non-blocking assignments. Every flop then
  // samples the pre-edge values, whatever the statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      period_start <= 1'b0;
      pwm          <= '0;
      sat          <= '0;
      // NOTE: this per-channel array is reset explicitly. It is a handful of
      // flops whose zero value is visible on cmd_eff, not a RAM.
      for (int i = 0; i < CHANNELS; i++) eff_q[i] <= '0;
    end else begin
      cnt_q        <= wrap ? '0 : cnt_q + CNT_W'(1);
      period_start <= wrap;
      pwm          <= pwm_d;
      if (wrap) begin
        sat <= sat_d;
        for (int i = 0; i < CHANNELS; i++) eff_q[i] <= eff_d[i];
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_eff_out
    assign cmd_eff[g*CMD_W +: CMD_W] = eff_q[g];
  end

endmodule

// File: tb/tb_multi_pwm_ramp_gen.sv
// -----------------------------------------------------------------------------
// tb_multi_pwm_ramp_gen
//
// Runs two instances of multi_pwm_ramp_gen with PERIOD=100 and CMD_MAX=100, so
// TPU=1. Instance a has no slew limit (RAMP_STEP=0). Instance b uses
// RAMP_STEP=10.
//
// The expectations for each PWM period are queued when the stimulus is driven.
// Each queued entry is then popped and compared over the following 100
// cycles. The cmd_eff/sat comparisons are made in the cycle where the counter
// is 0. The pwm widths and first-high positions are counted over the window
// from the cycle where cnt=1 to the cycle where cnt=0 of the next period.
// -----------------------------------------------------------------------------
module tb_multi_pwm_ramp_gen;

  localparam int PERIOD = 100;
  localparam int CMD_W  = 16;
`ifdef PWM_PHASE_STAGGER_EN
  localparam int R1_LOW_DUTY = 51;  // ch1 window starts at cnt 50, seen at 51
`else
  localparam int R1_LOW_DUTY = 1;
`endif

  typedef struct {
    string tag;
    int    e0;
    int    e1;
    int    s;
    int    r1;
  } exp_t;

  logic        clk;
  logic        rst_a, rst_b;
  logic        en_a, en_b;
  logic [31:0] cmd_a, cmd_b;
  logic [1:0]  pwm_a, pwm_b;
  logic        ps_a, ps_b;
  logic [31:0] eff_a, eff_b;
  logic [1:0]  sat_a, sat_b;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  multi_pwm_ramp_gen #(
    .CLK_HZ(1000), .PWM_HZ(10), .CHANNELS(2), .CMD_W(CMD_W),
    .CMD_MAX(100), .RAMP_STEP(0)
  ) u_dut_a (
    .clk(clk), .rst(rst_a), .enable(en_a), .rpm_command(cmd_a),
    .pwm(pwm_a), .period_start(ps_a), .cmd_eff(eff_a), .sat(sat_a)
  );

  multi_pwm_ramp_gen #(
    .CLK_HZ(1000), .PWM_HZ(10), .CHANNELS(2), .CMD_W(CMD_W),
    .CMD_MAX(100), .RAMP_STEP(10)
  ) u_dut_b (
    .clk(clk), .rst(rst_b), .enable(en_b), .rpm_command(cmd_b),
    .pwm(pwm_b), .period_start(ps_b), .cmd_eff(eff_b), .sat(sat_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic push(input string tag, input int e0, input int e1,
                      input int s, input int r1);
    exp_t e;
    e.tag = tag;
    e.e0  = e0;
    e.e1  = e1;
    e.s   = s;
    e.r1  = r1;
    exp_q.push_back(e);
  endtask

  // Called at the negedge following the last reset edge. Counts clock edges
  // until period_start is seen high, with a bound of 150.
  task automatic count_to_ps(input bit sel, input string tag);
    int n = 0;
    for (int i = 1; i <= 150 && n == 0; i++) begin
      @(negedge clk);
      if ((sel ? ps_b : ps_a) === 1'b1) n = i;
    end
    check(tag, n, PERIOD);
  endtask

  // Called at the negedge of a cycle where period_start is high. Optionally
  // changes the command mid-period, at the cycle where cnt == chg_at.
  task automatic measure(input bit sel, input int chg_at,
                         input logic [31:0] chg_cmd);
    exp_t        e;
    logic [31:0] eff;
    logic [1:0]  s, p;
    int          w0 = 0, w1 = 0, r0 = 0, r1 = 0, stray = 0;
    logic        ps_end = 1'b0;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 1, 0);
      return;
    end
    e   = exp_q.pop_front();
    eff = sel ? eff_b : eff_a;
    s   = sel ? sat_b : sat_a;
    check({e.tag, ".eff0"}, {16'd0, eff[15:0]}, e.e0);
    check({e.tag, ".eff1"}, {16'd0, eff[31:16]}, e.e1);
    check({e.tag, ".sat"}, {30'd0, s}, e.s);
    for (int k = 1; k <= PERIOD; k++) begin
      @(negedge clk);
      if (k == chg_at) begin
        if (sel) cmd_b = chg_cmd;
        else     cmd_a = chg_cmd;
      end
      p = sel ? pwm_b : pwm_a;
      if (p[0]) begin w0++; if (r0 == 0) r0 = k; end
      if (p[1]) begin w1++; if (r1 == 0) r1 = k; end
      if (k < PERIOD) begin
        if ((sel ? ps_b : ps_a) !== 1'b0) stray++;
      end else begin
        ps_end = sel ? ps_b : ps_a;
      end
    end
    check({e.tag, ".width0"}, w0, e.e0);
    check({e.tag, ".width1"}, w1, e.e1);
    check({e.tag, ".rise0"}, r0, (e.e0 > 0) ? 1 : 0);
    check({e.tag, ".rise1"}, r1, e.r1);
    check({e.tag, ".ps_stray"}, stray, 0);
    check({e.tag, ".ps_wrap"}, {31'd0, ps_end}, 1);
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    en_a  = 1'b1; en_b  = 1'b1;
    cmd_a = {16'd0, 16'd60};
    cmd_b = 32'd0;

    // Reset held for three edges: every output at zero.
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("rst.pwm_a", {30'd0, pwm_a}, 0);
      check("rst.eff_a", eff_a, 0);
      check("rst.sat_a", {30'd0, sat_a}, 0);
      check("rst.ps_a", {31'd0, ps_a}, 0);
      check("rst.pwm_b", {30'd0, pwm_b}, 0);
      check("rst.eff_b", eff_b, 0);
    end
    rst_a = 1'b0; rst_b = 1'b0;
    count_to_ps(1'b0, "rst.first_ps");

    // Instance a, no slew limit. The first boundary latched 60. A mid-period
    // change at cnt=20 has no effect until the next boundary.
    cmd_a = {16'd0, 16'd50};
    push("p1_60", 60, 0, 0, 0);
    measure(1'b0, -1, 32'd0);
    push("p2_50", 50, 0, 0, 0);
    measure(1'b0, 20, {16'd0, 16'd80});
    push("p3_80", 80, 0, 0, 0);
    measure(1'b0, -1, 32'd0);

    // Saturation of ch0 and full duty on both channels for several wraps.
    cmd_a = {16'd100, 16'd150};
    push("p4_80", 80, 0, 0, 0);
    measure(1'b0, -1, 32'd0);
    push("p5_full", 100, 100, 1, 1);
    measure(1'b0, -1, 32'd0);
    push("p6_full", 100, 100, 1, 1);
    measure(1'b0, -1, 32'd0);
    push("p7_full", 100, 100, 1, 1);
    measure(1'b0, -1, 32'd0);

    // Both channels at 20. With the stagger build, ch1 rises 50 cycles later.
    cmd_a = {16'd20, 16'd20};
    push("p8_full", 100, 100, 1, 1);
    measure(1'b0, -1, 32'd0);
    cmd_a = {16'd0, 16'd50};
    push("p9_20_20", 20, 20, 0, R1_LOW_DUTY);
    measure(1'b0, -1, 32'd0);

    // Instance b, RAMP_STEP=10: ramp up 0 -> 35.
    cmd_b = {16'd0, 16'd35};
    push("b_0", 0, 0, 0, 0);
    measure(1'b1, -1, 32'd0);
    push("b_up10", 10, 0, 0, 0);
    measure(1'b1, -1, 32'd0);
    push("b_up20", 20, 0, 0, 0);
    measure(1'b1, -1, 32'd0);
    push("b_up30", 30, 0, 0, 0);
    measure(1'b1, -1, 32'd0);
    push("b_up35", 35, 0, 0, 0);
    measure(1'b1, -1, 32'd0);
    cmd_b = {16'd0, 16'd30};
    push("b_hold35", 35, 0, 0, 0);
    measure(1'b1, -1, 32'd0);

    // Drop enable at 30: ramp down, then re-enable and ramp back up from 0.
    en_b = 1'b0;
    push("b_30", 30, 0, 0, 0);
    measure(1'b1, -1, 32'd0);
    push("b_dn20", 20, 0, 0, 0);
    measure(1'b1, -1, 32'd0);
    push("b_dn10", 10, 0, 0, 0);
    measure(1'b1, -1, 32'd0);
    en_b = 1'b1;
    push("b_dn0", 0, 0, 0, 0);
    measure(1'b1, -1, 32'd0);
    push("b_re10", 10, 0, 0, 0);
    measure(1'b1, -1, 32'd0);
    push("b_re20", 20, 0, 0, 0);
    measure(1'b1, -1, 32'd0);
    push("b_re30", 30, 0, 0, 0);
    measure(1'b1, -1, 32'd0);

    // Reset of instance a at cnt=40 while ch0 runs at duty 50.
    check("mid.eff_before", eff_a, 50);
    repeat (40) @(negedge clk);
    check("mid.pwm_before", {31'd0, pwm_a[0]}, 1);
    rst_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    check("mid.pwm_after", {30'd0, pwm_a}, 0);
    check("mid.eff_after", eff_a, 0);
    check("mid.sat_after", {30'd0, sat_a}, 0);
    check("mid.ps_after", {31'd0, ps_a}, 0);
    count_to_ps(1'b0, "mid.first_ps");
    check("mid.eff_relatch", eff_a, 50);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
